// File: rtl/cnt_mod.sv
// Parametrised up/down modulo counter with bounded load, wrap/saturate mode and registered terminal-count pulse.
// Optional sticky overflow flag (ovf/ovf_clr) is built only when CNT_OVF_STICKY_EN is defined.
module cnt_mod #(
  parameter int unsigned          WIDTH   = 4,
  parameter logic [WIDTH-1:0]     MIN_VAL = '0,
  parameter logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]     RST_VAL = MIN_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min
`ifdef CNT_OVF_STICKY_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             max_hit, min_hit;

  assign max_hit = (count_q == MAX_VAL);
  assign min_hit = (count_q == MIN_VAL);

  // Bounds are tested before stepping, so count never leaves [MIN_VAL, MAX_VAL] and never overflows.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      if (load_val > MAX_VAL)      count_d = MAX_VAL;
      else if (load_val < MIN_VAL) count_d = MIN_VAL;
      else                         count_d = load_val;
    end else if (en) begin
      if (up) begin
        if (max_hit) begin
          tc_d    = 1'b1;
          count_d = sat ? MAX_VAL : MIN_VAL;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (min_hit) begin
          tc_d    = 1'b1;
          count_d = sat ? MIN_VAL : MAX_VAL;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_VAL;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign at_max = max_hit;
  assign at_min = min_hit;

`ifdef CNT_OVF_STICKY_EN
  logic ovf_q, ovf_d;

  // A new bound event outranks a clear arriving on the same edge.
  always_comb begin
    ovf_d = tc_d | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cnt_mod.sv
// Directed bench for cnt_mod: default 0..15 counter, a 0..9 decade counter and a 3..12 counter (reset 5).
// Inputs are shared; each phase checks the instance(s) whose state it has set up.
module tb_cnt_mod;

  logic       clk;
  logic       rst;
  logic       en, up, load, sat;
  logic [3:0] load_val;

  logic [3:0] count0, count9, countb;
  logic       tc0, tc9, tcb;
  logic       amax0, amin0, amax9, amin9, amaxb, aminb;
`ifdef CNT_OVF_STICKY_EN
  logic       ovf_clr;
  logic       ovf0, ovf9, ovfb;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cnt_mod #(.WIDTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .sat(sat),
    .count(count0), .tc(tc0), .at_max(amax0), .at_min(amin0)
`ifdef CNT_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf(ovf0)
`endif
  );

  cnt_mod #(.WIDTH(4), .MIN_VAL(4'd0), .MAX_VAL(4'd9)) u_dut9 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .sat(sat),
    .count(count9), .tc(tc9), .at_max(amax9), .at_min(amin9)
`ifdef CNT_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf(ovf9)
`endif
  );

  cnt_mod #(.WIDTH(4), .MIN_VAL(4'd3), .MAX_VAL(4'd12), .RST_VAL(4'd5)) u_dutb (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val), .sat(sat),
    .count(countb), .tc(tcb), .at_max(amaxb), .at_min(aminb)
`ifdef CNT_OVF_STICKY_EN
    , .ovf_clr(ovf_clr), .ovf(ovfb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; sat = 1'b0; load_val = 4'd0;
`ifdef CNT_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) step();
    chk("rst_count0", 32'(count0), 0);
    chk("rst_tc0", 32'(tc0), 0);
    chk("rst_amin0", 32'(amin0), 1);
    chk("rst_amax0", 32'(amax0), 0);
    chk("rst_countb", 32'(countb), 5);
`ifdef CNT_OVF_STICKY_EN
    chk("rst_ovf9", 32'(ovf9), 0);
`endif
    rst = 1'b1;

    // Full-range count up and wrap on the default instance
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("up_count0", 32'(count0), 32'(i));
      chk("up_tc0", 32'(tc0), 0);
    end
    chk("amax0_15", 32'(amax0), 1);
    step();
    chk("wrap_count0", 32'(count0), 0);
    chk("wrap_tc0", 32'(tc0), 1);
    en = 1'b0;
    step();
    chk("tc0_one_cycle", 32'(tc0), 0);
    chk("hold_count0", 32'(count0), 0);

    // Decade counter counting down from reset
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    chk("rerst_count9", 32'(count9), 0);
    sat = 1'b0; up = 1'b0; en = 1'b1;
    step();
    chk("dn_wrap_count9", 32'(count9), 9);
    chk("dn_wrap_tc9", 32'(tc9), 1);
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("dn_count9", 32'(count9), 32'(9 - i));
      chk("dn_tc9", 32'(tc9), 0);
    end
    chk("dn_amin9", 32'(amin9), 1);

    // Saturate at max on the decade counter
    en = 1'b0; sat = 1'b1; load = 1'b1; load_val = 4'd7;
    step();
    chk("ld7_count9", 32'(count9), 7);
    load = 1'b0; en = 1'b1; up = 1'b1;
    begin
      int exp_c[5] = '{8, 9, 9, 9, 9};
      int exp_t[5] = '{0, 0, 1, 1, 1};
      int exp_m[5] = '{0, 1, 1, 1, 1};
      for (int i = 0; i < 5; i++) begin
        step();
        chk("sat_count9", 32'(count9), 32'(exp_c[i]));
        chk("sat_tc9", 32'(tc9), 32'(exp_t[i]));
        chk("sat_amax9", 32'(amax9), 32'(exp_m[i]));
      end
    end

    // Saturate at min on the 3..12 counter
    load = 1'b1; en = 1'b0; load_val = 4'd3;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    chk("satmin_countb", 32'(countb), 3);
    chk("satmin_tcb", 32'(tcb), 1);
    chk("satmin_aminb", 32'(aminb), 1);

    // Clamped loads and load priority over enable
    en = 1'b0; load = 1'b1; load_val = 4'd14;
    step();
    chk("clamp_hi_count9", 32'(count9), 9);
    chk("clamp_hi_tc9", 32'(tc9), 0);
    chk("noclamp_count0", 32'(count0), 14);
    chk("clamp_hi_countb", 32'(countb), 12);
    en = 1'b1; up = 1'b1; load_val = 4'd3;
    step();
    chk("ld_win_count9", 32'(count9), 3);
    chk("ld_win_tc9", 32'(tc9), 0);
    en = 1'b0; load_val = 4'd1;
    step();
    chk("clamp_lo_countb", 32'(countb), 3);
    chk("ld1_count9", 32'(count9), 1);
    load = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b0;
    step();
    chk("wrap_min_countb", 32'(countb), 12);
    chk("wrap_min_tcb", 32'(tcb), 1);
    chk("dec_count9", 32'(count9), 0);
    chk("dec_tc9", 32'(tc9), 0);

    // Asynchronous reset mid-cycle, with a tc pending on the decade counter
    en = 1'b0; load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    chk("pre_rst_tc9", 32'(tc9), 1);
    chk("pre_rst_count0", 32'(count0), 10);
    #3 rst = 1'b0;
    #1;
    chk("arst_count0", 32'(count0), 0);
    chk("arst_count9", 32'(count9), 0);
    chk("arst_countb", 32'(countb), 5);
    chk("arst_tc9", 32'(tc9), 0);
    en = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("post_rst_tc9", 32'(tc9), 0);
    chk("post_rst_countb", 32'(countb), 5);

`ifdef CNT_OVF_STICKY_EN
    // Sticky overflow: set, hold, set-beats-clear, clear
    chk("ovf9_idle", 32'(ovf9), 0);
    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
    step();
    chk("ovf9_set", 32'(ovf9), 1);
    en = 1'b0;
    step();
    chk("ovf9_hold", 32'(ovf9), 1);
    load = 1'b1;
    step();
    load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
    step();
    chk("ovf9_set_wins", 32'(ovf9), 1);
    chk("ovf9_set_wins_tc", 32'(tc9), 1);
    en = 1'b0;
    step();
    chk("ovf9_clr", 32'(ovf9), 0);
    ovf_clr = 1'b0;
    step();
    chk("ovf9_stay_clr", 32'(ovf9), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
